io_uart_tx_port: RTL

Memory-mapped serial output port on the CPU data/address bus, beside the 64K RAM and downstream of the accumulator store path. Captures CPU stores to a data address into a small FIFO and serializes each byte as an 8N1 UART frame on a single output pin. A status address lets the CPU poll FIFO state and a sticky overflow flag.

---
 rtl/io_uart_tx_port_if.sv | 22 ++
 rtl/io_uart_tx_port.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/io_uart_tx_port_if.sv
// CPU data/address bus bundle seen by the memory-mapped UART transmit port.
// The master drives address/data/strobes; the slave returns the status byte and its bus enable.
`timescale 1ns/1ps
interface io_uart_tx_port_if;
    logic [15:0] address;
    logic [7:0]  data_in;
    logic        wr_e;
    logic        re_e;
    logic        o_en;
    logic [7:0]  data_out;
    logic        data_oe;

    modport master (
        output address, data_in, wr_e, re_e, o_en,
        input  data_out, data_oe
    );

    modport slave (
        input  address, data_in, wr_e, re_e, o_en,
        output data_out, data_oe
    );
endinterface

// File: rtl/io_uart_tx_port.sv
// Memory-mapped UART transmitter: CPU stores are queued in a small FIFO and sent as 8N1 frames.
// Define UART_PARITY_EN to append an even-parity bit to every frame (8E1).
`timescale 1ns/1ps
module io_uart_tx_port #(
    parameter logic [15:0] PORT_ADDR    = 16'hFF00,
    parameter logic [15:0] STATUS_ADDR  = 16'hFF01,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    io_uart_tx_port_if.slave  bus,
    output logic              tx,
    output logic              busy,
    output logic              irq_empty
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_PARITY_EN
    localparam logic PARITY_FLAG = 1'b1;
`else
    localparam logic PARITY_FLAG = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state_reg;
    logic [BIT_W-1:0]   bit_cnt_reg;
    logic [2:0]         bit_idx_reg;
    logic [7:0]         shift_reg;
    logic               tx_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               overflow_reg;
    logic [7:0]         mem [FIFO_DEPTH];

    logic wr_strobe;
    logic rd_sel;
    logic fifo_empty;
    logic fifo_full;
    logic bit_done;
    logic pop;
    logic push;
    logic ovf_set;

    assign wr_strobe  = bus.wr_e & ~bus.o_en & (bus.address == PORT_ADDR);
    assign rd_sel     = bus.re_e & bus.o_en & (bus.address == STATUS_ADDR);
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign bit_done   = (bit_cnt_reg == BIT_W'(CLKS_PER_BIT - 1));

    // The shifter takes the head from IDLE, or straight from the end of STOP so frames abut.
    assign pop     = ~fifo_empty & ((state_reg == IDLE) | ((state_reg == STOP) & bit_done));
    assign push    = wr_strobe & (~fifo_full | pop);
    assign ovf_set = wr_strobe & fifo_full & ~pop;

    assign busy        = (state_reg != IDLE) | ~fifo_empty;
    assign irq_empty   = ~busy;
    assign tx          = tx_reg;
    assign bus.data_oe = rd_sel;
    assign bus.data_out = rd_sel ? {3'b000, PARITY_FLAG, busy, overflow_reg, fifo_full, fifo_empty}
                                 : 8'h00;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            // A fresh overflow on the same edge as a status read must stay visible.
            if (ovf_set) begin
                overflow_reg <= 1'b1;
            end else if (rd_sel) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg      <= 1'b1;
                    bit_cnt_reg <= '0;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr_reg];
                        state_reg <= START;
                        tx_reg    <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_cnt_reg <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= DATA;
                        tx_reg      <= shift_reg[0];
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
`ifdef UART_PARITY_EN
                            state_reg <= PARITY;
                            tx_reg    <= ^shift_reg;
`else
                            state_reg <= STOP;
                            tx_reg    <= 1'b1;
`endif
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            tx_reg      <= shift_reg[bit_idx_reg + 3'd1];
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        bit_cnt_reg <= '0;
                        state_reg   <= STOP;
                        tx_reg      <= 1'b1;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        bit_cnt_reg <= '0;
                        if (pop) begin
                            shift_reg <= mem[rd_ptr_reg];
                            state_reg <= START;
                            tx_reg    <= 1'b0;
                        end else begin
                            state_reg <= IDLE;
                            tx_reg    <= 1'b1;
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end
endmodule
